// File: rtl/cp0_regfile_mp.sv
// CP0 architectural register file with per-slot masked write channels,
// plus the free-running Count/Compare timer and TLB Random state.
module cp0_regfile_mp #(
    parameter int          TLB_ENTRIES = 16,
    parameter int          NUM_WPORTS  = 2,
    parameter int          COUNT_DIV   = 2,
    parameter logic [31:0] PRID_VAL    = 32'h00004220,
    parameter logic [31:0] CONFIG_RST  = 32'h80000003,
    localparam int         IDX_W       = $clog2(TLB_ENTRIES)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_WPORTS-1:0]    we,
    input  logic [NUM_WPORTS*5-1:0]  waddr,
    input  logic [NUM_WPORTS*3-1:0]  wsel,
    input  logic [NUM_WPORTS*32-1:0] wdata,
    input  logic [4:0]               raddr,
    input  logic [2:0]               rsel,
    output logic [31:0]              rdata,
    output logic                     timer_int,
    output logic [IDX_W-1:0]         random_o
);

    localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [PW-1:0]    PRE_TOP = PW'(COUNT_DIV - 1);
    localparam logic [IDX_W-1:0] RND_TOP = IDX_W'(TLB_ENTRIES - 1);

    localparam logic [4:0] R_RANDOM  = 5'd1;
    localparam logic [4:0] R_WIRED   = 5'd6;
    localparam logic [4:0] R_COUNT   = 5'd9;
    localparam logic [4:0] R_COMPARE = 5'd11;
    localparam logic [4:0] R_STATUS  = 5'd12;
    localparam logic [4:0] R_CAUSE   = 5'd13;
    localparam logic [4:0] R_PRID    = 5'd15;
    localparam logic [4:0] R_CONFIG  = 5'd16;
    localparam logic [31:0] EB_MASK  = 32'h3ffff000;

    function automatic logic [31:0] wmask0(input logic [4:0] a);
        logic [31:0] m;
        case (a)
            5'd0, 5'd6:          m = {{(32-IDX_W){1'b0}}, {IDX_W{1'b1}}};
            5'd2, 5'd3:          m = 32'h7fffffff;
            5'd4:                m = 32'hff800000;
            5'd5:                m = 32'h1ffff000;
            5'd9, 5'd11,
            5'd14, 5'd30:        m = 32'hffffffff;
            5'd10:               m = 32'hfffff0ff;
            5'd12:               m = 32'hfa78ff17;
            5'd13:               m = 32'h00c00300;
            5'd16:               m = 32'h00000007;
            default:             m = 32'h0;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] rst_val(input logic [4:0] a);
        logic [31:0] v;
        case (a)
            R_STATUS: v = 32'h00400000;
            R_CONFIG: v = CONFIG_RST;
            default:  v = 32'h0;
        endcase
        return v;
    endfunction

    logic [31:0]      r   [32];
    logic [31:0]      r_n [32];
    logic [31:0]      ebase, ebase_n;
    logic [IDX_W-1:0] rnd, rnd_n;
    logic [PW-1:0]    pre, pre_n;
    logic             ti, ti_n;
    logic             cnt_wr, cmp_wr, wired_wr;
    logic [4:0]       pa;
    logic [2:0]       ps;
    logic [31:0]      pd, m;
    logic [IDX_W-1:0] wired;

    assign wired = r[R_WIRED][IDX_W-1:0];

    // Ports are walked in program order so a later slot overwrites an earlier one.
    always_comb begin
        cnt_wr   = 1'b0;
        cmp_wr   = 1'b0;
        wired_wr = 1'b0;
        pa       = '0;
        ps       = '0;
        pd       = '0;
        m        = '0;
        ebase_n  = ebase;
        for (int a = 0; a < 32; a++) r_n[a] = r[a];
        for (int p = 0; p < NUM_WPORTS; p++) begin
            pa = waddr[p*5 +: 5];
            ps = wsel[p*3 +: 3];
            pd = wdata[p*32 +: 32];
            m  = wmask0(pa);
            if (we[p] && ps == 3'd0) begin
                r_n[pa] = (r[pa] & ~m) | (pd & m);
                if (pa == R_COUNT)   cnt_wr   = 1'b1;
                if (pa == R_COMPARE) cmp_wr   = 1'b1;
                if (pa == R_WIRED)   wired_wr = 1'b1;
            end else if (we[p] && ps == 3'd1 && pa == R_PRID) begin
                ebase_n = (ebase & ~EB_MASK) | (pd & EB_MASK);
            end
        end

        if (!cnt_wr && pre == PRE_TOP) r_n[R_COUNT] = r[R_COUNT] + 32'd1;
        pre_n = (cnt_wr || pre == PRE_TOP) ? '0 : pre + PW'(1);

        if (cmp_wr)                            ti_n = 1'b0;
        else if (r[R_COUNT] == r[R_COMPARE])   ti_n = 1'b1;
        else                                   ti_n = ti;

        if (wired_wr || wired >= RND_TOP)      rnd_n = RND_TOP;
        else if (rnd == wired || rnd == '0)    rnd_n = RND_TOP;
        else                                   rnd_n = rnd - IDX_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int a = 0; a < 32; a++) r[a] <= rst_val(5'(a));
            ebase <= 32'h80000000;
            rnd   <= RND_TOP;
            pre   <= '0;
            ti    <= 1'b0;
        end else begin
            for (int a = 0; a < 32; a++) r[a] <= r_n[a];
            ebase <= ebase_n;
            rnd   <= rnd_n;
            pre   <= pre_n;
            ti    <= ti_n;
        end
    end

    always_comb begin
        rdata = '0;
        if (rsel == 3'd0) begin
            case (raddr)
                R_RANDOM: rdata = {{(32-IDX_W){1'b0}}, rnd};
                R_CAUSE:  rdata = r[R_CAUSE] | {1'b0, ti, 14'b0, ti, 15'b0};
                R_PRID:   rdata = PRID_VAL;
                default:  rdata = r[raddr];
            endcase
        end else if (rsel == 3'd1 && raddr == R_PRID) begin
            rdata = ebase;
        end
    end

    assign timer_int = ti;
    assign random_o  = rnd;

endmodule

// File: tb/tb_cp0_regfile_mp.sv
// Scoreboard bench for cp0_regfile_mp: reset, masking, port priority,
// timer, Random sequencing and Count wrap/overwrite.
module tb_cp0_regfile_mp;

    localparam int NW = 2;

    logic           clk;
    logic           rst;
    logic [NW-1:0]  we;
    logic [NW*5-1:0]  waddr;
    logic [NW*3-1:0]  wsel;
    logic [NW*32-1:0] wdata;
    logic [4:0]     raddr;
    logic [2:0]     rsel;
    logic [31:0]    rdata;
    logic           timer_int;
    logic [3:0]     random_o;

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    cp0_regfile_mp dut (
        .clk       (clk),
        .rst       (rst),
        .we        (we),
        .waddr     (waddr),
        .wsel      (wsel),
        .wdata     (wdata),
        .raddr     (raddr),
        .rsel      (rsel),
        .rdata     (rdata),
        .timer_int (timer_int),
        .random_o  (random_o)
    );

    initial begin
        clk = 1'b0;
        forever #50 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %08h want %08h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input int p, input logic [4:0] a, input logic [2:0] s,
                      input logic [31:0] d);
        we[p]          = 1'b1;
        waddr[p*5 +: 5]  = a;
        wsel[p*3 +: 3]   = s;
        wdata[p*32 +: 32] = d;
    endtask

    task automatic commit();
        tick();
        we = '0;
    endtask

    task automatic rd(input logic [4:0] a, input logic [2:0] s,
                      input logic [31:0] want, input string tag);
        exp_q.push_back(want);
        tag_q.push_back(tag);
        raddr = a;
        rsel  = s;
        #1;
        chk(tag_q.pop_front(), rdata, exp_q.pop_front());
    endtask

    initial begin
        rst = 1'b1; we = '0; waddr = '0; wsel = '0; wdata = '0;
        raddr = '0; rsel = '0;

        // T1 reset
        tick();
        rst = 1'b0;
        rd(5'd1, 3'd0, 32'h0000000f, "rst_random");
        rd(5'd12, 3'd0, 32'h00400000, "rst_status");
        rd(5'd15, 3'd1, 32'h80000000, "rst_ebase");
        rd(5'd9, 3'd0, 32'h00000000, "rst_count");
        rd(5'd16, 3'd0, 32'h80000003, "rst_config");
        rd(5'd15, 3'd0, 32'h00004220, "rst_prid");
        chk("rst_ti", 32'(timer_int), 32'h0);

        wr(0, 5'd11, 3'd0, 32'hffff0000);
        commit();
        chk("cmp_clear_ti", 32'(timer_int), 32'h0);

        // T2 masking
        wr(0, 5'd12, 3'd0, 32'hffffffff); commit();
        wr(0, 5'd13, 3'd0, 32'hffffffff); commit();
        wr(0, 5'd0,  3'd0, 32'hffffffff); commit();
        wr(0, 5'd15, 3'd0, 32'hffffffff); commit();
        wr(0, 5'd4,  3'd0, 32'hffffffff); commit();
        wr(0, 5'd15, 3'd1, 32'hffffffff); commit();
        wr(0, 5'd16, 3'd0, 32'h00000000); commit();
        wr(0, 5'd8,  3'd0, 32'hffffffff); commit();
        rd(5'd12, 3'd0, 32'hfa78ff17, "mask_status");
        rd(5'd13, 3'd0, 32'h00c00300, "mask_cause");
        rd(5'd0,  3'd0, 32'h0000000f, "mask_index");
        rd(5'd15, 3'd0, 32'h00004220, "mask_prid");
        rd(5'd4,  3'd0, 32'hff800000, "mask_context");
        rd(5'd15, 3'd1, 32'hbffff000, "mask_ebase");
        rd(5'd16, 3'd0, 32'h80000000, "mask_config");
        rd(5'd8,  3'd0, 32'h00000000, "ro_badvaddr");

        // T3 port priority
        wr(0, 5'd14, 3'd0, 32'h11111111);
        wr(1, 5'd14, 3'd0, 32'h22222222);
        commit();
        rd(5'd14, 3'd0, 32'h22222222, "conf_epc");
        wr(0, 5'd14, 3'd0, 32'h33333333);
        wr(1, 5'd30, 3'd0, 32'h44444444);
        commit();
        rd(5'd14, 3'd0, 32'h33333333, "dual_epc");
        rd(5'd30, 3'd0, 32'h44444444, "dual_errorepc");
        wr(0, 5'd13, 3'd0, 32'hffffffff);
        wr(1, 5'd13, 3'd0, 32'h00000000);
        wr(0, 5'd12, 3'd0, 32'h00000000);
        commit();
        wr(0, 5'd12, 3'd0, 32'h00000000);
        wr(1, 5'd12, 3'd0, 32'hffffffff);
        commit();
        rd(5'd13, 3'd0, 32'h00000000, "nomerge_cause");
        rd(5'd12, 3'd0, 32'hfa78ff17, "nomerge_status");

        // T4 timer
        wr(0, 5'd11, 3'd0, 32'h00000005);
        wr(1, 5'd9,  3'd0, 32'h00000000);
        commit();
        for (int i = 0; i < 10; i++) tick();
        rd(5'd9, 3'd0, 32'h00000005, "tmr_count5");
        chk("tmr_pre_ti", 32'(timer_int), 32'h0);
        tick();
        chk("tmr_rise", 32'(timer_int), 32'h1);
        rd(5'd13, 3'd0, 32'h40008000, "tmr_cause");
        tick();
        chk("tmr_sticky", 32'(timer_int), 32'h1);
        wr(0, 5'd11, 3'd0, 32'hffff0000);
        commit();
        chk("tmr_clear", 32'(timer_int), 32'h0);

        wr(0, 5'd9,  3'd0, 32'd100);
        wr(1, 5'd11, 3'd0, 32'd100);
        commit();
        chk("tmr_setup", 32'(timer_int), 32'h0);
        wr(0, 5'd11, 3'd0, 32'd100);
        commit();
        chk("tmr_cmpwins", 32'(timer_int), 32'h0);
        tick();
        chk("tmr_rematch", 32'(timer_int), 32'h1);
        wr(0, 5'd11, 3'd0, 32'hffff0000);
        commit();

        // T6 count wrap and overwrite
        wr(0, 5'd9, 3'd0, 32'hffffffff);
        commit();
        rd(5'd9, 3'd0, 32'hffffffff, "wrap_c0");
        tick();
        rd(5'd9, 3'd0, 32'hffffffff, "wrap_c1");
        tick();
        rd(5'd9, 3'd0, 32'h00000000, "wrap_c2");
        tick();
        wr(0, 5'd9, 3'd0, 32'h12345678);
        commit();
        rd(5'd9, 3'd0, 32'h12345678, "cwr_exact");
        tick();
        rd(5'd9, 3'd0, 32'h12345678, "cwr_hold");
        tick();
        rd(5'd9, 3'd0, 32'h12345679, "cwr_inc");

        // T5 Random
        wr(0, 5'd6, 3'd0, 32'h00000003);
        commit();
        exp_q.push_back(32'hf);
        for (int i = 1; i <= 12; i++) exp_q.push_back(32'(15 - i));
        exp_q.push_back(32'hf);
        for (int i = 0; i < 14; i++) begin
            raddr = 5'd1;
            rsel  = 3'd0;
            #1;
            chk("rnd_out", 32'(random_o), exp_q[0]);
            chk("rnd_seq", rdata, exp_q.pop_front());
            tick();
        end
        wr(0, 5'd6, 3'd0, 32'h0000000f);
        commit();
        for (int i = 0; i < 3; i++) begin
            chk("rnd_pin", 32'(random_o), 32'hf);
            tick();
        end
        wr(0, 5'd6, 3'd0, 32'h00000003);
        commit();
        tick();
        tick();
        chk("rnd_mid", 32'(random_o), 32'hd);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rnd_rst", 32'(random_o), 32'hf);
        rd(5'd6,  3'd0, 32'h00000000, "rst2_wired");
        rd(5'd12, 3'd0, 32'h00400000, "rst2_status");
        rd(5'd14, 3'd0, 32'h00000000, "rst2_epc");
        chk("rst2_ti", 32'(timer_int), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
